// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg
//   Shared types and constants for the monitor-ROM port arbiter.
//   - REQ_CPU / REQ_SHADOW : requester ids carried through the tag pipeline
//   - rom_tag_t            : (valid, id) entry of the in-flight read pipeline
//   - arb_state_t          : last-grant pointer of the round-robin arbiter
//   - rom_latency_legal()  : elaboration check for the ROM_LATENCY parameter
package rom_arb_pkg;

    localparam logic REQ_CPU    = 1'b0;
    localparam logic REQ_SHADOW = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } rom_tag_t;

    // The pointer names the requester granted most recently; on a tie the
    // other requester wins. Reset value is ST_LAST_SHADOW so the CPU wins
    // the first tie after reset.
    typedef enum logic {
        ST_LAST_CPU    = 1'b0,
        ST_LAST_SHADOW = 1'b1
    } arb_state_t;

    // Only a plain registered read (1) or a read with the output register
    // enabled (2) is supported by the ROM macro.
    function automatic bit rom_latency_legal(int latency);
        return (latency == 1) || (latency == 2);
    endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if
//   Bundles the two requester ports, the ROM address/data pair and the
//   arbiter state debug signal.
//   Handshake: a requester raises reqN with a stable addrN and keeps both
//   stable until it sees the one-cycle gntN pulse; it may drop reqN in the
//   grant cycle. Read data comes back later as a one-cycle rvalidN pulse with
//   rdataN, in grant order; rdataN holds its value between pulses. There is
//   no backpressure on the response side.
//   modport slave  : arbiter side
//   modport master : requesters + ROM side (testbench / SBC top level)
interface rom_port_arbiter_if
    import rom_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 14
);
    logic                  req0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic                  gnt0;
    logic                  rvalid0;
    logic [DATA_WIDTH-1:0] rdata0;

    logic                  req1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic                  gnt1;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata1;

    logic [ADDR_WIDTH-1:0] rom_address;
    logic [DATA_WIDTH-1:0] rom_data;

    arb_state_t            arb_state;

    modport slave (
        input  req0, addr0, req1, addr1, rom_data,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_address,
        output arb_state
    );

    modport master (
        output req0, addr0, req1, addr1, rom_data,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_address,
        input  arb_state
    );
endinterface

// File: rtl/rom_arb_tagpipe.sv
// rom_arb_tagpipe
//   (valid, id) shift register tracking reads in flight through the ROM.
//   An entry is shifted in every cycle (valid=0 when nothing was granted) and
//   emerges DEPTH cycles later, aligned with the ROM output for that read.
//   Ports:
//     clock, reset : rising-edge clock, synchronous active-high clear
//     push_tag     : entry entering the pipeline this cycle
//     tail_tag     : entry leaving the pipeline this cycle
module rom_arb_tagpipe
    import rom_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clock,
    input  logic     reset,
    input  rom_tag_t push_tag,
    output rom_tag_t tail_tag
);
    rom_tag_t stage_q [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= push_tag;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tail_tag = stage_q[DEPTH-1];
endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//   Shares one single-port registered-read ROM between the CPU read path
//   (requester 0) and the boot shadow-copy engine (requester 1). Round-robin
//   arbitration, registered ROM address, and response steering by a tag
//   pipeline so data returns to the requester that issued the read.
//   Ports:
//     clock, reset : rising-edge clock, synchronous active-high reset
//     bus          : requester ports, ROM address/data, arbiter state
//   Parameters:
//     DATA_WIDTH, ADDR_WIDTH : ROM word / address width (match the interface)
//     ROM_LATENCY            : ROM read latency, 1 or 2 cycles
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 14,
    parameter int ROM_LATENCY = 1
) (
    input  logic               clock,
    input  logic               reset,
    rom_port_arbiter_if.slave  bus
);
    if (!rom_latency_legal(ROM_LATENCY)) begin : g_bad_latency
        $error("rom_port_arbiter: ROM_LATENCY must be 1 or 2");
    end

    arb_state_t            state_q, state_d;
    logic                  gnt0_q, gnt1_q;
    logic                  win0, win1;
    logic [ADDR_WIDTH-1:0] rom_address_q;
    rom_tag_t              push_tag, tail_tag;
    logic                  rvalid0_q, rvalid1_q;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

    // Arbitration: a requester is not eligible in its own grant cycle, which
    // is what lets the requester keep req high until it observes gnt.
    always_comb begin
        state_d  = state_q;
        win0     = 1'b0;
        win1     = 1'b0;
        push_tag = '0;

        if (bus.req0 && !gnt0_q &&
            (!(bus.req1 && !gnt1_q) || state_q == ST_LAST_SHADOW)) begin
            win0 = 1'b1;
        end else if (bus.req1 && !gnt1_q) begin
            win1 = 1'b1;
        end

        if (win0) begin
            state_d = ST_LAST_CPU;
        end else if (win1) begin
            state_d = ST_LAST_SHADOW;
        end

        push_tag.valid = win0 | win1;
        push_tag.id    = win1 ? REQ_SHADOW : REQ_CPU;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_LAST_SHADOW;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            rom_address_q <= '0;
        end else begin
            state_q <= state_d;
            gnt0_q  <= win0;
            gnt1_q  <= win1;
            // Address holds when idle; the idle reads are simply untagged.
            if (win0) begin
                rom_address_q <= bus.addr0;
            end else if (win1) begin
                rom_address_q <= bus.addr1;
            end
        end
    end

    // Depth ROM_LATENCY+1: one stage for the address register, then one per
    // ROM latency cycle, so the tail lines up with valid rom_data.
    rom_arb_tagpipe #(
        .DEPTH (ROM_LATENCY + 1)
    ) u_tagpipe (
        .clock    (clock),
        .reset    (reset),
        .push_tag (push_tag),
        .tail_tag (tail_tag)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= tail_tag.valid && (tail_tag.id == REQ_CPU);
            rvalid1_q <= tail_tag.valid && (tail_tag.id == REQ_SHADOW);
            if (tail_tag.valid && (tail_tag.id == REQ_CPU)) begin
                rdata0_q <= bus.rom_data;
            end
            if (tail_tag.valid && (tail_tag.id == REQ_SHADOW)) begin
                rdata1_q <= bus.rom_data;
            end
        end
    end

    assign bus.gnt0        = gnt0_q;
    assign bus.gnt1        = gnt1_q;
    assign bus.rom_address = rom_address_q;
    assign bus.rvalid0     = rvalid0_q;
    assign bus.rvalid1     = rvalid1_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
    assign bus.arb_state   = state_q;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter
//   Two arbiter instances: u_dut_a with ROM_LATENCY=1 and u_dut_b with
//   ROM_LATENCY=2, each with its own ROM model. Directed steps drive the
//   requesters; expected read data is queued when a request is driven and
//   popped by a monitor on every rvalid pulse.
module tb_rom_port_arbiter;
    import rom_arb_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    rom_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(14)) bus_a ();
    rom_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(14)) bus_b ();

    rom_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(14), .ROM_LATENCY(1)) u_dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    rom_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(14), .ROM_LATENCY(2)) u_dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    function automatic logic [7:0] rom_word(logic [13:0] a);
        return a[7:0] ^ {a[13:8], 2'b01} ^ 8'h5A;
    endfunction

    // ROM models: registered read, plus an output register for instance B.
    logic [7:0] rom_b_stage;
    always @(posedge clock) begin
        bus_a.rom_data <= rom_word(bus_a.rom_address);
        rom_b_stage    <= rom_word(bus_b.rom_address);
        bus_b.rom_data <= rom_b_stage;
    end

    logic [7:0] qa0[$];
    logic [7:0] qa1[$];
    logic [7:0] qb0[$];
    logic [7:0] qb1[$];

    task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cycles(int n);
        repeat (n) tick();
    endtask

    // Scoreboard: every rvalid pulse must match the oldest queued word.
    always @(posedge clock) begin
        #2;
        if (bus_a.rvalid0) begin
            check("a_rsp0_expected", 32'(qa0.size() != 0), 1);
            if (qa0.size() != 0) check("a_rdata0", 32'(bus_a.rdata0), 32'(qa0.pop_front()));
        end
        if (bus_a.rvalid1) begin
            check("a_rsp1_expected", 32'(qa1.size() != 0), 1);
            if (qa1.size() != 0) check("a_rdata1", 32'(bus_a.rdata1), 32'(qa1.pop_front()));
        end
        if (bus_b.rvalid0) begin
            check("b_rsp0_expected", 32'(qb0.size() != 0), 1);
            if (qb0.size() != 0) check("b_rdata0", 32'(bus_b.rdata0), 32'(qb0.pop_front()));
        end
        if (bus_b.rvalid1) begin
            check("b_rsp1_expected", 32'(qb1.size() != 0), 1);
            if (qb1.size() != 0) check("b_rdata1", 32'(bus_b.rdata1), 32'(qb1.pop_front()));
        end
    end

    task automatic check_a_idle(string tag);
        check({tag, "_gnt0"},    32'(bus_a.gnt0), 0);
        check({tag, "_gnt1"},    32'(bus_a.gnt1), 0);
        check({tag, "_rvalid0"}, 32'(bus_a.rvalid0), 0);
        check({tag, "_rvalid1"}, 32'(bus_a.rvalid1), 0);
        check({tag, "_rdata0"},  32'(bus_a.rdata0), 0);
        check({tag, "_rdata1"},  32'(bus_a.rdata1), 0);
        check({tag, "_rom_addr"}, 32'(bus_a.rom_address), 0);
        check({tag, "_ptr"},     32'(bus_a.arb_state), 1);
    endtask

    logic [13:0] cur0, cur1;

    initial begin
        reset       = 1'b1;
        bus_a.req0  = 1'b0;  bus_a.addr0 = '0;
        bus_a.req1  = 1'b0;  bus_a.addr1 = '0;
        bus_b.req0  = 1'b0;  bus_b.addr0 = '0;
        bus_b.req1  = 1'b0;  bus_b.addr1 = '0;

        // Reset values, and a request raised during reset.
        cycles(2);
        check_a_idle("rst");
        check("b_rst_gnt1", 32'(bus_b.gnt1), 0);
        check("b_rst_rvalid1", 32'(bus_b.rvalid1), 0);
        bus_a.req1  = 1'b1;
        bus_a.addr1 = 14'h0005;
        qa1.push_back(rom_word(14'h0005));
        tick();
        check("a_gnt1_during_reset", 32'(bus_a.gnt1), 0);
        reset = 1'b0;
        tick();
        check("a_gnt1_after_reset", 32'(bus_a.gnt1), 1);
        check("a_addr_after_reset", 32'(bus_a.rom_address), 32'h0005);
        bus_a.req1 = 1'b0;
        cycles(2);
        check("a_rvalid1_after_reset", 32'(bus_a.rvalid1), 1);
        tick();

        // Single requester, address 0.
        bus_a.req0  = 1'b1;
        bus_a.addr0 = 14'h0000;
        qa0.push_back(rom_word(14'h0000));
        tick();
        check("single_gnt0", 32'(bus_a.gnt0), 1);
        check("single_gnt1", 32'(bus_a.gnt1), 0);
        check("single_addr", 32'(bus_a.rom_address), 0);
        bus_a.req0 = 1'b0;
        tick();
        check("single_gnt0_pulse", 32'(bus_a.gnt0), 0);
        tick();
        check("single_rvalid0", 32'(bus_a.rvalid0), 1);
        check("single_rvalid1", 32'(bus_a.rvalid1), 0);
        tick();
        check("single_rvalid0_pulse", 32'(bus_a.rvalid0), 0);

        // Simultaneous requests right after reset: CPU wins the first tie.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("tie_ptr_reset", 32'(bus_a.arb_state), 1);
        bus_a.req0 = 1'b1;  bus_a.addr0 = 14'h0010;
        bus_a.req1 = 1'b1;  bus_a.addr1 = 14'h0020;
        qa0.push_back(rom_word(14'h0010));
        qa1.push_back(rom_word(14'h0020));
        tick();
        check("tie_c1_gnt0", 32'(bus_a.gnt0), 1);
        check("tie_c1_gnt1", 32'(bus_a.gnt1), 0);
        check("tie_c1_addr", 32'(bus_a.rom_address), 32'h0010);
        bus_a.req0 = 1'b0;
        tick();
        check("tie_c2_gnt1", 32'(bus_a.gnt1), 1);
        check("tie_c2_gnt0", 32'(bus_a.gnt0), 0);
        check("tie_c2_addr", 32'(bus_a.rom_address), 32'h0020);
        bus_a.req1 = 1'b0;
        tick();
        check("tie_c3_rvalid0", 32'(bus_a.rvalid0), 1);
        check("tie_c3_rvalid1", 32'(bus_a.rvalid1), 0);
        tick();
        check("tie_c4_rvalid1", 32'(bus_a.rvalid1), 1);
        check("tie_c4_rvalid0", 32'(bus_a.rvalid0), 0);

        // Both requesters held high: ten alternating grants.
        cur0 = 14'h0100;
        cur1 = 14'h0200;
        bus_a.req0 = 1'b1;  bus_a.addr0 = cur0;
        bus_a.req1 = 1'b1;  bus_a.addr1 = cur1;
        qa0.push_back(rom_word(cur0));
        qa1.push_back(rom_word(cur1));
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i % 2 == 0) begin
                check("alt_gnt0", 32'(bus_a.gnt0), 1);
                check("alt_gnt1_idle", 32'(bus_a.gnt1), 0);
                check("alt_addr0", 32'(bus_a.rom_address), 32'(cur0));
                if (i < 8) begin
                    cur0 = 14'($urandom_range(0, 16383));
                    bus_a.addr0 = cur0;
                    qa0.push_back(rom_word(cur0));
                end else begin
                    bus_a.req0 = 1'b0;
                end
            end else begin
                check("alt_gnt1", 32'(bus_a.gnt1), 1);
                check("alt_gnt0_idle", 32'(bus_a.gnt0), 0);
                check("alt_addr1", 32'(bus_a.rom_address), 32'(cur1));
                if (i < 8) begin
                    cur1 = 14'($urandom_range(0, 16383));
                    bus_a.addr1 = cur1;
                    qa1.push_back(rom_word(cur1));
                end else begin
                    bus_a.req1 = 1'b0;
                end
            end
        end
        cycles(4);
        check("alt_q0_drained", 32'(qa0.size()), 0);
        check("alt_q1_drained", 32'(qa1.size()), 0);

        // Reset in the cycle after a grant drops that read entirely.
        bus_a.req0  = 1'b1;
        bus_a.addr0 = 14'h0123;
        tick();
        check("flush_gnt0", 32'(bus_a.gnt0), 1);
        bus_a.req0 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_a_idle("flush");
        reset = 1'b0;
        cycles(3);
        check("flush_no_rvalid0", 32'(bus_a.rvalid0), 0);
        bus_a.req0  = 1'b1;
        bus_a.addr0 = 14'h0042;
        qa0.push_back(rom_word(14'h0042));
        tick();
        check("fresh_gnt0", 32'(bus_a.gnt0), 1);
        bus_a.req0 = 1'b0;
        cycles(2);
        check("fresh_rvalid0", 32'(bus_a.rvalid0), 1);

        // req0 held across two grants with the address changed in between.
        tick();
        bus_a.req0  = 1'b1;
        bus_a.addr0 = 14'h3FFF;
        qa0.push_back(rom_word(14'h3FFF));
        tick();
        check("hold_gnt0_first", 32'(bus_a.gnt0), 1);
        check("hold_addr_first", 32'(bus_a.rom_address), 32'h3FFF);
        bus_a.addr0 = 14'h0001;
        qa0.push_back(rom_word(14'h0001));
        tick();
        check("hold_no_dup_gnt", 32'(bus_a.gnt0), 0);
        tick();
        check("hold_gnt0_second", 32'(bus_a.gnt0), 1);
        check("hold_addr_second", 32'(bus_a.rom_address), 32'h0001);
        bus_a.req0 = 1'b0;
        tick();
        check("hold_gnt0_end", 32'(bus_a.gnt0), 0);
        cycles(3);

        // ROM_LATENCY=2 instance: back-to-back req1.
        bus_b.req1  = 1'b1;
        bus_b.addr1 = 14'h0777;
        qb1.push_back(rom_word(14'h0777));
        tick();
        check("lat2_gnt1_first", 32'(bus_b.gnt1), 1);
        check("lat2_addr_first", 32'(bus_b.rom_address), 32'h0777);
        bus_b.addr1 = 14'h0778;
        qb1.push_back(rom_word(14'h0778));
        tick();
        check("lat2_gnt1_gap", 32'(bus_b.gnt1), 0);
        tick();
        check("lat2_gnt1_second", 32'(bus_b.gnt1), 1);
        check("lat2_addr_second", 32'(bus_b.rom_address), 32'h0778);
        check("lat2_rvalid1_early", 32'(bus_b.rvalid1), 0);
        bus_b.req1 = 1'b0;
        tick();
        check("lat2_rvalid1_first", 32'(bus_b.rvalid1), 1);
        check("lat2_rvalid0", 32'(bus_b.rvalid0), 0);
        tick();
        check("lat2_rvalid1_gap", 32'(bus_b.rvalid1), 0);
        tick();
        check("lat2_rvalid1_second", 32'(bus_b.rvalid1), 1);
        cycles(4);

        check("end_qa0_empty", 32'(qa0.size()), 0);
        check("end_qa1_empty", 32'(qa1.size()), 0);
        check("end_qb0_empty", 32'(qb0.size()), 0);
        check("end_qb1_empty", 32'(qb1.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
